// File: rtl/cla_pkg.sv
// Shared constants, FSM state type and sizing helper for the nibble-serial CLA adder.
package cla_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bits needed to count n nibbles; never less than one so a 4-bit build still has a counter.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < n) r++;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/cla4_core.sv
// Combinational 4-bit carry-lookahead adder; carries come from generate/propagate terms, not a ripple chain.
module cla4_core (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign sum  = p ^ c[3:0];
   assign cout = c[4];

endmodule

// File: rtl/cla_seq_adder.sv
// WIDTH-bit add/sub built from one shared cla4_core, processing one nibble per clock.
module cla_seq_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output state_t           dbg_state
);

   localparam int NIB = WIDTH / NIB_W;
   localparam int CW  = clog2(NIB);

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             carry;
   logic [3:0]       a_nib;
   logic [3:0]       b_nib;
   logic [3:0]       core_sum;
   logic             core_cout;
   logic             last_nib;

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
   // Operands transfer only in IDLE, results only in DONE; both ready/valid outputs decode
   // registered state, so no input reaches an output combinationally.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign last_nib  = (cnt == CW'(NIB - 1));

   always_comb begin
      a_nib = '0;
      b_nib = '0;
      for (int k = 0; k < NIB; k++) begin
         if (cnt == CW'(k)) begin
            a_nib = a_reg[k*NIB_W +: NIB_W];
            b_nib = b_reg[k*NIB_W +: NIB_W];
         end
      end
   end

   cla4_core u_core (
      .a    (a_nib),
      .b    (b_nib),
      .cin  (carry),
      .sum  (core_sum),
      .cout (core_cout)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = RUN;
         RUN:     if (last_nib) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         a_reg   <= '0;
         b_reg   <= '0;
         sum_reg <= '0;
         carry   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  // Subtraction is a + ~b + 1, so the inverted operand and forced carry are latched here.
                  a_reg   <= a;
                  b_reg   <= sub ? ~b : b;
                  carry   <= sub ? 1'b1 : cin;
                  cnt     <= '0;
                  sum_reg <= '0;
               end
            end
            RUN: begin
               for (int k = 0; k < NIB; k++) begin
                  if (cnt == CW'(k)) sum_reg[k*NIB_W +: NIB_W] <= core_sum;
               end
               carry <= core_cout;
               cnt   <= last_nib ? '0 : cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign sum       = sum_reg;
   assign cout      = carry;
   assign ovf       = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum_reg[WIDTH-1] != a_reg[WIDTH-1]);
   assign dbg_state = state;

endmodule
